// File: rtl/axis_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_packer
// Brief    : Captures one H_ACTIVE x V_ACTIVE frame per start pulse into an
//            AXI-Stream packet for DMA S2MM through a FWFT skid FIFO.
//            Build option LINE_LAST_EN: assert last at the end of every line.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  axi_Mclk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic [3:0]            m_axis_keep,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  ovf
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int c_VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [c_HW-1:0] c_H_LAST = c_HW'(H_ACTIVE - 1);
  localparam logic [c_VW-1:0] c_V_LAST = c_VW'(V_ACTIVE - 1);
  localparam logic [c_PW:0]   c_FULL   = (c_PW + 1)'(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_ONE    = (c_PW + 1)'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [c_HW-1:0]       r_h_cnt;
  logic [c_VW-1:0]       r_v_cnt;
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [c_PW:0]         r_wr_ptr;
  logic [c_PW:0]         r_rd_ptr;
  logic [c_PW:0]         w_count;
  logic [DATA_WIDTH:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_line_end;
  logic                  w_frame_pix;
  logic                  w_last_flag;
  logic                  w_frame_end;
  logic                  r_frame_done;
  logic [15:0]           r_frame_cnt;
  logic                  r_ovf;

  // FIFO status
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == c_FULL);
  assign w_head  = r_mem[r_rd_ptr[c_PW-1:0]];
  assign w_pop   = !w_empty && m_axis_ready;
  assign w_push  = s_axis_valid && w_ready;

  assign w_line_end  = (r_h_cnt == c_H_LAST);
  assign w_frame_pix = w_line_end && (r_v_cnt == c_V_LAST);
`ifdef LINE_LAST_EN
  assign w_last_flag = w_line_end;
`else
  assign w_last_flag = w_frame_pix;
`endif

  // In DRAIN no pushes occur, so the sole remaining entry is the frame's final pixel.
  assign w_frame_end = (r_state == c_DRAIN) && w_pop && (w_count == c_ONE);

  always_ff @(posedge axi_Mclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (start) w_next = c_RUN;
      c_RUN:   if (w_push && w_frame_pix) w_next = c_DRAIN;
      c_DRAIN: if (w_frame_end) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // A full FIFO still accepts when its head leaves in the same cycle.
  always_comb begin
    w_ready = (r_state == c_RUN) && (!w_full || m_axis_ready);
    w_busy  = (r_state != c_IDLE);
  end

  always_ff @(posedge axi_Mclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_push) begin
      if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else if (r_state == c_IDLE) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  always_ff @(posedge axi_Mclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge axi_Mclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_PW-1:0]] <= {s_axis_data, w_last_flag};
    end
  end

  always_ff @(posedge axi_Mclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (start && (r_state != c_IDLE)) r_ovf <= 1'b1;
    end
  end

  // Head payload is masked so stale memory never leaks out while empty.
  assign s_axis_ready = w_ready;
  assign m_axis_valid = !w_empty;
  assign m_axis_data  = w_empty ? '0 : w_head[DATA_WIDTH:1];
  assign m_axis_last  = !w_empty && w_head[0];
  assign m_axis_keep  = {4{!w_empty}};
  assign busy         = w_busy;
  assign frame_done   = r_frame_done;
  assign frame_cnt    = r_frame_cnt;
  assign ovf          = r_ovf;

endmodule
`default_nettype wire
